// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: shared CPU encodings and ROM size for the fetch stage
package instr_fetch_unit_pkg;
  localparam int unsigned ROM_BYTES = 100;
  typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_BR = 2'b01, PC_J = 2'b10, PC_HOLD = 2'b11} pc_src_e;
  typedef enum logic [1:0] {S_IDLE, S_READ, S_FAULT} state_e;
endpackage

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection relative to the fetched word's pc+4
module next_pc_calc
  import instr_fetch_unit_pkg::*;
(
  input  logic [31:0] pc_plus4,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_target,
  input  pc_src_e     pc_src,
  output logic [31:0] next_pc
);
  always_comb next_pc = pc_src == PC_BR ? pc_plus4 + {{14{br_imm[15]}}, br_imm, 2'b00}
                      : pc_src == PC_J  ? {pc_plus4[31:28], j_target, 2'b00}
                      : pc_plus4;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, ROM read sequencing and instruction register for the multi-cycle CPU
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0,
  parameter int unsigned ROM_BYTES   = instr_fetch_unit_pkg::ROM_BYTES,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_go,
  input  logic        pc_wen,
  input  logic [1:0]  pc_src,
  input  logic [15:0] br_imm,
  input  logic [25:0] j_target,
  input  logic        halt,
  output logic        rom_nrd,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_data,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        ir_valid,
  output logic        busy,
  output logic        fault
);
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, ir_pc_q, ir_pc_d, pend_q, pend_d, cnt_q, cnt_d, npc;
  logic        ir_valid_q, ir_valid_d, pend_v_q, pend_v_d, wr, go, bad, last;

  next_pc_calc u_npc (
    .pc_plus4 (pc_plus4),
    .br_imm   (br_imm),
    .j_target (j_target),
    .pc_src   (pc_src_e'(pc_src)),
    .next_pc  (npc)
  );

  assign wr   = pc_wen && pc_src != PC_HOLD;
  assign go   = fetch_go && !halt;
  // 33-bit compare so a PC near 2^32 cannot wrap into the legal range
  assign bad  = pc_q[1:0] != 2'b00 || {1'b0, pc_q} + 33'd3 >= 33'(ROM_BYTES);
  assign last = cnt_q == '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    pend_d     = pend_q;
    pend_v_d   = pend_v_q;
    cnt_d      = cnt_q;
    if (state_q == S_IDLE) begin
      pc_d = wr ? npc : pc_q;
      if (go) begin
        state_d    = bad ? S_FAULT : S_READ;
        cnt_d      = WAIT_CYCLES - 1;
        ir_valid_d = bad && ir_valid_q;
      end
    end else if (state_q == S_READ) begin
      cnt_d    = cnt_q - 1;
      pend_d   = wr ? npc : pend_q;
      pend_v_d = wr || pend_v_q;
      if (last) begin
        state_d    = S_IDLE;
        ir_d       = rom_data;
        ir_pc_d    = pc_q;
        ir_valid_d = 1'b1;
        pc_d       = wr ? npc : pend_v_q ? pend_q : pc_q;
        pend_v_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      ir_pc_q    <= RESET_PC;
      ir_valid_q <= 1'b0;
      pend_q     <= '0;
      pend_v_q   <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
      pend_q     <= pend_d;
      pend_v_q   <= pend_v_d;
      cnt_q      <= cnt_d;
    end
  end

  assign rom_nrd  = state_q != S_READ;
  assign busy     = state_q == S_READ;
  assign fault    = state_q == S_FAULT;
  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;
  assign pc_plus4 = ir_pc_q + 32'd4;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench over WAIT_CYCLES=1/3 and two faulting reset PCs
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;
  typedef struct {logic [31:0] ir; logic [31:0] pc;} exp_t;
  exp_t sbq[$];
  int n_cmp = 0, n_bad = 0;
  logic clk = 0, rst = 1, fetch_go = 0, pc_wen = 0, halt = 0;
  logic [1:0]  pc_src = PC_SEQ;
  logic [15:0] br_imm = '0;
  logic [25:0] j_target = '0;
  logic [7:0]  rom [0:127];
  logic        nrd1, v1, busy1, fault1, nrd3, v3, busy3, fault3;
  logic [31:0] addr1, d1, ir1, pc1, p41, addr3, d3, ir3, pc3, p43;
  logic [1:0]  fx_nrd, fx_v, fx_busy, fx_fault;
  logic [31:0] fx_addr [2], fx_ir [2], fx_pc [2], fx_p4 [2];
  logic [31:0] fpc [2] = '{32'h62, 32'h2};

  always #5 clk = ~clk;

  always_comb d1 = addr1 < 125 ? {rom[addr1[6:0]], rom[addr1[6:0] + 7'd1], rom[addr1[6:0] + 7'd2], rom[addr1[6:0] + 7'd3]} : 32'h0;
  always_comb d3 = addr3 < 125 ? {rom[addr3[6:0]], rom[addr3[6:0] + 7'd1], rom[addr3[6:0] + 7'd2], rom[addr3[6:0] + 7'd3]} : 32'h0;

  instr_fetch_unit #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_wen(pc_wen), .pc_src(pc_src), .br_imm(br_imm),
    .j_target(j_target), .halt(halt), .rom_nrd(nrd1), .rom_addr(addr1), .rom_data(d1), .ir(ir1),
    .pc(pc1), .pc_plus4(p41), .ir_valid(v1), .busy(busy1), .fault(fault1));

  instr_fetch_unit #(.WAIT_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_wen(pc_wen), .pc_src(pc_src), .br_imm(br_imm),
    .j_target(j_target), .halt(halt), .rom_nrd(nrd3), .rom_addr(addr3), .rom_data(d3), .ir(ir3),
    .pc(pc3), .pc_plus4(p43), .ir_valid(v3), .busy(busy3), .fault(fault3));

  for (genvar g = 0; g < 2; g++) begin : gf
    instr_fetch_unit #(.RESET_PC(g == 0 ? 32'h62 : 32'h2)) u (
      .clk(clk), .rst(rst), .fetch_go(fetch_go), .pc_wen(pc_wen), .pc_src(pc_src), .br_imm(br_imm),
      .j_target(j_target), .halt(halt), .rom_nrd(fx_nrd[g]), .rom_addr(fx_addr[g]), .rom_data(32'h0),
      .ir(fx_ir[g]), .pc(fx_pc[g]), .pc_plus4(fx_p4[g]), .ir_valid(fx_v[g]), .busy(fx_busy[g]), .fault(fx_fault[g]));
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [6:0] i = a[6:0];
    return {rom[i], rom[i + 7'd1], rom[i + 7'd2], rom[i + 7'd3]};
  endfunction

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_reset();
    rst = 1; fetch_go = 0; pc_wen = 0; halt = 0; pc_src = PC_SEQ; br_imm = '0; j_target = '0;
    tick(); tick(); rst = 0;
  endtask

  task automatic write_pc(input logic [1:0] src, input logic [15:0] imm, input logic [25:0] jt);
    pc_wen = 1; pc_src = src; br_imm = imm; j_target = jt; tick(); pc_wen = 0;
  endtask

  task automatic fetch1(input logic [31:0] a);
    exp_t e;
    int n = 0;
    sbq.push_back('{word(a), a});
    fetch_go = 1; tick(); fetch_go = 0;
    while (!v1 && n < 20) begin tick(); n++; end
    e = sbq.pop_front();
    n_cmp++; if (v1 !== 1'b1) begin n_bad++; $display("FAIL fetch_timeout @%h: ir_valid=%b need 1", a, v1); end
    n_cmp++; if (ir1 !== e.ir) begin n_bad++; $display("FAIL fetch_ir @%h: got %h need %h", a, ir1, e.ir); end
    n_cmp++; if (p41 !== e.pc + 32'd4) begin n_bad++; $display("FAIL fetch_pc4 @%h: got %h need %h", a, p41, e.pc + 32'd4); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pc1 !== 32'h0 || addr1 !== 32'h0) begin n_bad++; $display("FAIL reset_pc: pc=%h addr=%h need 0", pc1, addr1); end
    n_cmp++; if (ir1 !== 32'h0 || v1 !== 1'b0) begin n_bad++; $display("FAIL reset_ir: ir=%h v=%b need 0/0", ir1, v1); end
    n_cmp++; if ({nrd1, busy1, fault1} !== 3'b100) begin n_bad++; $display("FAIL reset_ctl: nrd/busy/fault=%b need 100", {nrd1, busy1, fault1}); end
    n_cmp++; if (p41 !== 32'h4) begin n_bad++; $display("FAIL reset_pc4: got %h need 4", p41); end
  endtask

  task automatic test_first_fetch();
    exp_t e;
    sbq.push_back('{32'h20010005, 32'h0});
    fetch_go = 1; tick(); fetch_go = 0;
    n_cmp++; if ({nrd1, busy1} !== 2'b01) begin n_bad++; $display("FAIL ff_t1: nrd/busy=%b need 01", {nrd1, busy1}); end
    tick();
    n_cmp++; if ({nrd1, busy1, v1} !== 3'b101) begin n_bad++; $display("FAIL ff_t2: nrd/busy/v=%b need 101", {nrd1, busy1, v1}); end
    e = sbq.pop_front();
    n_cmp++; if (ir1 !== e.ir) begin n_bad++; $display("FAIL ff_ir: got %h need %h", ir1, e.ir); end
    n_cmp++; if (p41 !== 32'h4) begin n_bad++; $display("FAIL ff_pc4: got %h need 4", p41); end
  endtask

  task automatic test_seq_branch();
    write_pc(PC_SEQ, 16'h0, 26'h0);
    n_cmp++; if (pc1 !== 32'h4 || addr1 !== 32'h4) begin n_bad++; $display("FAIL seq: pc=%h addr=%h need 4", pc1, addr1); end
    fetch1(32'h4);
    write_pc(PC_BR, 16'hFFFF, 26'h0);
    n_cmp++; if (pc1 !== 32'h4) begin n_bad++; $display("FAIL br_neg: got %h need 4", pc1); end
    write_pc(PC_BR, 16'h0002, 26'h0);
    n_cmp++; if (pc1 !== 32'h10) begin n_bad++; $display("FAIL br_pos: got %h need 10", pc1); end
  endtask

  task automatic test_jump();
    write_pc(PC_J, 16'h0, 26'h5);
    n_cmp++; if (pc1 !== 32'h14) begin n_bad++; $display("FAIL jump: got %h need 14", pc1); end
    write_pc(PC_HOLD, 16'h7, 26'h9);
    n_cmp++; if (pc1 !== 32'h14) begin n_bad++; $display("FAIL hold: got %h need 14", pc1); end
    fetch1(32'h14);
  endtask

  task automatic test_write_during_read();
    exp_t e;
    do_reset();
    sbq.push_back('{word(32'h0), 32'h0});
    fetch_go = 1; tick(); fetch_go = 0;
    n_cmp++; if ({nrd3, busy3} !== 2'b01) begin n_bad++; $display("FAIL wdr_c1: nrd/busy=%b need 01", {nrd3, busy3}); end
    tick(); pc_wen = 1; pc_src = PC_SEQ; tick(); pc_wen = 0;
    n_cmp++; if (pc3 !== 32'h0 || busy3 !== 1'b1) begin n_bad++; $display("FAIL wdr_c3: pc=%h busy=%b need 0/1", pc3, busy3); end
    tick();
    e = sbq.pop_front();
    n_cmp++; if ({nrd3, busy3, v3} !== 3'b101) begin n_bad++; $display("FAIL wdr_exit: nrd/busy/v=%b need 101", {nrd3, busy3, v3}); end
    n_cmp++; if (pc3 !== 32'h4 || p43 !== e.pc + 32'd4) begin n_bad++; $display("FAIL wdr_pc: pc=%h pc4=%h need 4/%h", pc3, p43, e.pc + 32'd4); end
    n_cmp++; if (ir3 !== e.ir) begin n_bad++; $display("FAIL wdr_ir: got %h need %h", ir3, e.ir); end
    sbq.push_back('{word(32'h4), 32'h4});
    fetch_go = 1; tick(); fetch_go = 0;
    write_pc(PC_BR, 16'h0005, 26'h0);
    pc_wen = 1; pc_src = PC_SEQ; fetch_go = 1; tick(); pc_wen = 0; fetch_go = 0;
    tick();
    e = sbq.pop_front();
    n_cmp++; if (pc3 !== 32'h4 || p43 !== 32'h8) begin n_bad++; $display("FAIL wdr_overwrite: pc=%h pc4=%h need 4/8", pc3, p43); end
    n_cmp++; if (ir3 !== e.ir || v3 !== 1'b1) begin n_bad++; $display("FAIL wdr_ir2: ir=%h v=%b need %h/1", ir3, v3, e.ir); end
    tick();
    n_cmp++; if (busy3 !== 1'b0) begin n_bad++; $display("FAIL wdr_go_ignored: busy=%b need 0", busy3); end
  endtask

  task automatic test_halt();
    do_reset();
    fetch1(32'h0);
    halt = 1; fetch_go = 1; tick(); fetch_go = 0;
    n_cmp++; if ({busy1, nrd1, v1} !== 3'b011) begin n_bad++; $display("FAIL halt: busy/nrd/v=%b need 011", {busy1, nrd1, v1}); end
    halt = 0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    write_pc(PC_J, 16'h0, 26'h5);
    fetch_go = 1; tick(); fetch_go = 0; tick();
    rst = 1; tick(); rst = 0;
    n_cmp++; if (ir3 !== 32'h0 || v3 !== 1'b0 || pc3 !== 32'h0) begin n_bad++; $display("FAIL midrst: ir=%h v=%b pc=%h need 0/0/0", ir3, v3, pc3); end
    tick(); tick();
    n_cmp++; if (ir3 !== 32'h0 || v3 !== 1'b0 || busy3 !== 1'b0) begin n_bad++; $display("FAIL midrst_late: ir=%h v=%b busy=%b need 0/0/0", ir3, v3, busy3); end
  endtask

  task automatic test_fault();
    do_reset();
    fetch_go = 1; tick(); fetch_go = 0;
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if ({fx_fault[g], fx_nrd[g], fx_busy[g]} !== 3'b110) begin n_bad++; $display("FAIL fault_t1[%0d]: fault/nrd/busy=%b need 110", g, {fx_fault[g], fx_nrd[g], fx_busy[g]}); end
    end
    fetch_go = 1; write_pc(PC_SEQ, 16'h0, 26'h0); fetch_go = 0; tick();
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if (fx_pc[g] !== fpc[g] || {fx_fault[g], fx_nrd[g], fx_v[g]} !== 3'b110) begin n_bad++; $display("FAIL fault_sticky[%0d]: pc=%h f/nrd/v=%b need %h/110", g, fx_pc[g], {fx_fault[g], fx_nrd[g], fx_v[g]}, fpc[g]); end
    end
    rst = 1; tick(); rst = 0;
    for (int g = 0; g < 2; g++) begin
      n_cmp++; if (fx_fault[g] !== 1'b0 || fx_pc[g] !== fpc[g]) begin n_bad++; $display("FAIL fault_clear[%0d]: fault=%b pc=%h need 0/%h", g, fx_fault[g], fx_pc[g], fpc[g]); end
    end
  endtask

  task automatic test_range();
    do_reset();
    write_pc(PC_J, 16'h0, 26'd25);
    fetch_go = 1; tick(); fetch_go = 0;
    n_cmp++; if ({fault1, nrd1} !== 2'b11) begin n_bad++; $display("FAIL range_64: fault/nrd=%b need 11", {fault1, nrd1}); end
    do_reset();
    write_pc(PC_J, 16'h0, 26'd24);
    fetch1(32'h60);
    n_cmp++; if (fault1 !== 1'b0) begin n_bad++; $display("FAIL range_60: fault=%b need 0", fault1); end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = 8'(i * 37 + 11);
    rom[0] = 8'h20; rom[1] = 8'h01; rom[2] = 8'h00; rom[3] = 8'h05;
    test_reset();
    test_first_fetch();
    test_seq_branch();
    test_jump();
    test_write_during_read();
    test_halt();
    test_mid_reset();
    test_fault();
    test_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the multi-cycle CPU: owns the program counter, drives the read strobe and byte address of the big-endian instruction ROM, and latches the returned word into the instruction register for the control unit. Each fetch is started by a one-cycle request from the control unit and completes after a programmable wait period. Next-PC selection (sequential, branch, jump, hold) is also computed here. Misaligned or out-of-range fetches raise a sticky fault.

## Interface
- `RESET_PC`, default 32'h0: PC value after reset.
- `ROM_BYTES`, default 100: ROM size in bytes; a legal fetch needs pc+3 < ROM_BYTES.
- `WAIT_CYCLES`, default 1: cycles `rom_nrd` is held low before capture; must be ≥1.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_go` in 1: one-cycle fetch request from the control unit.
- `pc_wen` in 1: PC write enable.
- `pc_src` in 2: next-PC source: 00 sequential, 01 branch, 10 jump, 11 hold.
- `br_imm` in 16: branch offset in words, sign-extended.
- `j_target` in 26: jump word index.
- `halt` in 1: when high, `fetch_go` is ignored.
- `rom_nrd` out 1: ROM read strobe, active-low.
- `rom_addr` out 32: ROM byte address; always equals `pc`.
- `rom_data` in 32: ROM read data, big-endian word.
- `ir` out 32: instruction register.
- `pc` out 32: current PC.
- `pc_plus4` out 32: `ir_pc`+4, where `ir_pc` is the address of the word in `ir`.
- `ir_valid` out 1: `ir` holds a completed fetch.
- `busy` out 1: high in READ.
- `fault` out 1: sticky fetch fault.

## Operation
- FSM states: IDLE, READ, FAULT. Reset enters IDLE.
- Reset values: `pc`=RESET_PC, `ir`=0, `ir_pc`=RESET_PC, `ir_valid`=0, `busy`=0, `fault`=0, `rom_nrd`=1, pending slot empty.
- IDLE, `fetch_go`=1 and `halt`=0:
  - If `pc[1:0]`≠0 or pc+3 ≥ ROM_BYTES: go to FAULT.
  - Otherwise: go to READ, load wait counter with WAIT_CYCLES-1, clear `ir_valid`.
- READ: `rom_nrd`=0. Counter decrements each cycle. In the cycle the counter is 0: `ir`←`rom_data`, `ir_pc`←`pc`, `ir_valid`←1, return to IDLE.
- FAULT: `fault`=1 and `rom_nrd`=1 until `rst`. `fetch_go` and `pc_wen` are ignored.
- PC update when `pc_wen`=1 (all arithmetic is modulo 2^32):
  - 00: `pc_plus4`.
  - 01: `pc_plus4` + (sext(`br_imm`) << 2).
  - 10: {`pc_plus4`[31:28], `j_target`, 2'b00}.
  - 11: no change.
- `pc_wen` in IDLE: applied at that edge.
- `pc_wen` in READ: the computed value is stored in a one-entry pending slot. A second write in the same READ overwrites the slot. The slot is committed to `pc` on the edge that leaves READ, after `ir_pc` captures the old `pc`.
- `fetch_go` together with `pc_wen` in IDLE: the fetch uses the old `pc`; `pc` updates at the same edge.
- `fetch_go` while in READ or FAULT: ignored, not queued.
- `rst` during READ: the fetch is abandoned and no `ir` write occurs.

## Timing
- Latency with WAIT_CYCLES=N: `fetch_go` at cycle t, `rom_nrd` low during cycles t+1..t+N, `ir_valid`=1 from t+N+1.
- `busy` high exactly during cycles t+1..t+N.
- `ir` is stable while `ir_valid`=1.
- `rom_addr` is registered; `rom_data` is sampled only in the last READ cycle.
- `fault` is asserted at t+1 for an illegal fetch.

## Structure
- Shared CPU package holds:
  - The `pc_src` encodings: PC_SEQ, PC_BR, PC_J, PC_HOLD.
  - The FSM state enum.
  - ROM_BYTES.
- The next-PC arithmetic goes in a combinational sub-module `next_pc_calc` (inputs `pc_plus4`, `br_imm`, `j_target`, `pc_src`; output next pc). The FSM, counter and registers stay in `instr_fetch_unit`.

## Test plan
- **Reset and first fetch:** reset, ROM bytes 0..3 = 20 01 00 05, `fetch_go` at t, WAIT_CYCLES=1 → `rom_nrd` low only at t+1; `ir`=32'h20010005 and `ir_valid`=1 at t+2; `pc_plus4`=4.
- **Sequential then branch:** after the fetch at 0, `pc_wen`/PC_SEQ → `pc`=4. Fetch at 4, then PC_BR with `br_imm`=16'hFFFF → `pc`=4.
- **Jump:** `pc_plus4`=32'h8, PC_J, `j_target`=26'h5 → `pc`=32'h14.
- **Write during READ:** WAIT_CYCLES=3, PC_SEQ asserted in the 2nd READ cycle → `pc` stays unchanged until the exit edge, then equals `ir_pc`+4; `ir_pc` holds the old pc.
- **Fault cases:** `pc`=32'h62 with ROM_BYTES=100 → `fault`=1 at t+1; `rom_nrd` stays 1; later `fetch_go` and `pc_wen` have no effect; `rst` clears `fault`. Repeat with `pc`=32'h2 (misaligned) → same fault behaviour.
- **Halt and mid-fetch reset:** `halt`=1 with `fetch_go` → no READ and `ir_valid` unchanged. `rst` in the middle of READ → `ir`=0, `ir_valid`=0, `pc`=RESET_PC.
